// File: rtl/risc16_bus_pkg.sv
// Shared types and constants for the risc16 memory-port arbiter.
// Holds the DMA sequencer state encoding and the default LED register addresses.
package risc16_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } bus_arb_state_t;

    localparam logic [15:0] LED_LO_ADDR = 16'h0200;
    localparam logic [15:0] LED_HI_ADDR = 16'h0202;

endpackage

// File: rtl/risc16_dma_seq.sv
// DMA burst sequencer: IDLE/BURST/DONE state machine plus the burst address,
// direction and word-count registers. The grant comes from the top level and
// tells the sequencer that the current word moved this cycle.
module risc16_dma_seq
    import risc16_bus_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [15:0]      addr_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             grant_i,
    output logic             burst_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [15:0]      addr_o,
    output logic             we_o
);

    // Counter is one bit wider so a zero length can hold the full 2^LEN_W words.
    localparam logic [LEN_W:0] CNT_ONE  = (LEN_W + 1)'(1);
    localparam logic [LEN_W:0] CNT_FULL = CNT_ONE << LEN_W;

    bus_arb_state_t   state_q, state_d;
    logic [15:0]      addr_q, addr_d;
    logic [LEN_W:0]   cnt_q, cnt_d;
    logic             dir_q, dir_d;

    // State and burst registers; reset aborts any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge values; blocking would let later lines see updated state.
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    // Next-state logic: latch on request, step on grant, finish on the last word.
    always_comb begin
        // NOTE: every output of this block gets a default first, otherwise a
        // path that skips an assignment would infer a latch.
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    state_d = BURST;
                    addr_d  = {addr_i[15:1], 1'b0};
                    dir_d   = we_i;
                    cnt_d   = (len_i == '0) ? CNT_FULL : {1'b0, len_i};
                end
            end
            BURST: begin
                if (grant_i) begin
                    addr_d = addr_q + 16'd2;
                    cnt_d  = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign burst_o = (state_q == BURST);
    assign busy_o  = (state_q != IDLE);
    assign done_o  = (state_q == DONE);
    assign addr_o  = addr_q;
    assign we_o    = dir_q;

endmodule

// File: rtl/risc16_bus_arbiter.sv
// Memory-port arbiter between the risc16 core and a burst DMA master.
// The CPU path is purely combinational and always wins; DMA words move only
// on cycles where the CPU drives neither strobe.
// Build option: define RISC16_BUS_MMIO_LED_EN to decode CPU writes to the
// LED_LO/LED_HI addresses into the 24-bit led register instead of memory.
module risc16_bus_arbiter
    import risc16_bus_pkg::*;
#(
    parameter int          LEN_W  = 8,
    parameter logic [15:0] LED_LO = LED_LO_ADDR,
    parameter logic [15:0] LED_HI = LED_HI_ADDR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      cpu_addr,
    input  logic [15:0]      cpu_dout,
    output logic [15:0]      cpu_din,
    input  logic             cpu_oe,
    input  logic             cpu_we,
    input  logic             dma_req,
    input  logic             dma_we,
    input  logic [15:0]      dma_addr,
    input  logic [LEN_W-1:0] dma_len,
    input  logic [15:0]      dma_wdata,
    output logic             dma_ack,
    output logic [15:0]      dma_rdata,
    output logic             dma_rvalid,
    output logic             dma_busy,
    output logic             dma_done,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    input  logic [15:0]      mem_rdata,
    output logic             mem_oe,
    output logic             mem_we,
    output logic [23:0]      led
);

`ifdef RISC16_BUS_MMIO_LED_EN
    localparam bit MMIO_EN = 1'b1;
`else
    localparam bit MMIO_EN = 1'b0;
`endif

    logic        burst;
    logic [15:0] burst_addr;
    logic        burst_we;
    logic        led_lo_wr;
    logic        led_hi_wr;
    logic [15:0] dma_rdata_q;
    logic        dma_rvalid_q;
    logic [23:0] led_q;

    risc16_dma_seq #(
        .LEN_W (LEN_W)
    ) u_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (dma_req),
        .we_i    (dma_we),
        .addr_i  (dma_addr),
        .len_i   (dma_len),
        .grant_i (dma_ack),
        .burst_o (burst),
        .busy_o  (dma_busy),
        .done_o  (dma_done),
        .addr_o  (burst_addr),
        .we_o    (burst_we)
    );

    // DMA only gets the port on cycles the CPU leaves idle.
    assign dma_ack = burst & ~cpu_oe & ~cpu_we;

    // LED decode: a CPU write (including oe+we together) to either LED address.
    assign led_lo_wr = MMIO_EN && cpu_we && (cpu_addr == LED_LO);
    assign led_hi_wr = MMIO_EN && cpu_we && (cpu_addr == LED_HI);

    // Memory port mux: DMA on granted cycles, otherwise straight CPU pass-through.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_dout;
        mem_oe    = cpu_oe;
        mem_we    = cpu_we & ~(led_lo_wr | led_hi_wr);
        if (dma_ack) begin
            mem_addr  = burst_addr;
            mem_wdata = dma_wdata;
            mem_oe    = ~burst_we;
            mem_we    = burst_we;
        end
    end

    // Capture read-burst data; rvalid marks the cycle after each read grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dma_rdata_q  <= '0;
            dma_rvalid_q <= 1'b0;
        end else begin
            dma_rvalid_q <= dma_ack & ~burst_we;
            if (dma_ack && !burst_we) begin
                dma_rdata_q <= mem_rdata;
            end
        end
    end

    // LED register; stays at zero when the MMIO decode is compiled out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= '0;
        end else begin
            if (led_lo_wr) begin
                led_q[15:0] <= cpu_dout;
            end
            if (led_hi_wr) begin
                led_q[23:16] <= cpu_dout[7:0];
            end
        end
    end

    assign cpu_din    = mem_rdata;
    assign dma_rdata  = dma_rdata_q;
    assign dma_rvalid = dma_rvalid_q;
    assign led        = led_q;

endmodule

// File: tb/tb_risc16_bus_arbiter.sv
// Bench for risc16_bus_arbiter: a word memory driven by the DUT's memory port,
// a shadow memory plus burst bookkeeping updated from the arbitration rules,
// and directed scenarios mixed with random CPU traffic.
module tb_risc16_bus_arbiter;

    localparam int LEN_W = 8;
`ifdef RISC16_BUS_MMIO_LED_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [15:0]      cpu_addr, cpu_dout, cpu_din;
    logic             cpu_oe, cpu_we;
    logic             dma_req, dma_we;
    logic [15:0]      dma_addr;
    logic [LEN_W-1:0] dma_len;
    logic [15:0]      dma_wdata;
    logic             dma_ack;
    logic [15:0]      dma_rdata;
    logic             dma_rvalid, dma_busy, dma_done;
    logic [15:0]      mem_addr, mem_wdata, mem_rdata;
    logic             mem_oe, mem_we;
    logic [23:0]      led;

    always #5 clk = ~clk;

    logic [15:0] mem     [0:32767];
    logic [15:0] ref_mem [0:32767];

    assign mem_rdata = mem[mem_addr[15:1]];
    always @(posedge clk) if (mem_we) mem[mem_addr[15:1]] <= mem_wdata;

    risc16_bus_arbiter #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_din    (cpu_din),
        .cpu_oe     (cpu_oe),
        .cpu_we     (cpu_we),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_len    (dma_len),
        .dma_wdata  (dma_wdata),
        .dma_ack    (dma_ack),
        .dma_rdata  (dma_rdata),
        .dma_rvalid (dma_rvalid),
        .dma_busy   (dma_busy),
        .dma_done   (dma_done),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_oe     (mem_oe),
        .mem_we     (mem_we),
        .led        (led)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Reference: words still owed by the active burst (0 = none), the one-cycle
    // completion flag, burst address/direction and next source word index.
    int          m_rem, m_addr, m_idx;
    bit          m_done, m_dir;
    bit          exp_rvalid;
    logic [15:0] exp_rdata;
    logic [23:0] exp_led;
    logic [15:0] wq [0:511];

    int cyc = 0;
    int req_cyc, n_ack, n_rv, n_done, first_ack, last_ack, done_cyc;
    int ack_addrs[$];

    function automatic bit led_hit(input logic [15:0] a);
        return MMIO && (a == 16'h0200 || a == 16'h0202);
    endfunction

    task automatic model_reset();
        m_rem = 0; m_done = 0; m_dir = 0; m_addr = 0; m_idx = 0;
        exp_rvalid = 0; exp_rdata = '0; exp_led = '0;
    endtask

    task automatic clear_stats();
        n_ack = 0; n_rv = 0; n_done = 0;
        first_ack = -1; last_ack = -1; done_cyc = -1;
        ack_addrs.delete();
    endtask

    task automatic fill_wq();
        for (int i = 0; i < 512; i++) wq[i] = 16'($urandom);
    endtask

    // One clock: check the combinational port, advance the reference over the
    // edge, then check the registered outputs. Inputs are set at the negedge.
    task automatic tick();
        bit ack;
        dma_wdata = wq[m_idx];
        #1;
        ack = (m_rem > 0) && !cpu_oe && !cpu_we;
        check("dma_ack", dma_ack, ack);
        check("dma_busy", dma_busy, (m_rem > 0) || m_done);
        check("cpu_din", cpu_din, mem_rdata);
        if (ack) begin
            check("dma_mem_addr", mem_addr, m_addr);
            check("dma_mem_we", mem_we, m_dir);
            check("dma_mem_oe", mem_oe, !m_dir);
            if (m_dir) check("dma_mem_wdata", mem_wdata, wq[m_idx]);
            n_ack++;
            if (first_ack < 0) first_ack = cyc;
            last_ack = cyc;
            ack_addrs.push_back(m_addr);
        end else begin
            check("cpu_mem_addr", mem_addr, cpu_addr);
            check("cpu_mem_oe", mem_oe, cpu_oe);
            check("cpu_mem_we", mem_we, cpu_we && !led_hit(cpu_addr));
            check("cpu_mem_wdata", mem_wdata, cpu_dout);
        end
        @(posedge clk);
        exp_rvalid = ack && !m_dir;
        if (ack && !m_dir) exp_rdata = ref_mem[m_addr / 2];
        if (ack && m_dir)  ref_mem[m_addr / 2] = wq[m_idx];
        if (cpu_we) begin
            if (led_hit(cpu_addr)) begin
                if (cpu_addr == 16'h0200) exp_led[15:0] = cpu_dout;
                else                      exp_led[23:16] = cpu_dout[7:0];
            end else begin
                ref_mem[cpu_addr[15:1]] = cpu_dout;
            end
        end
        if (m_done) begin
            m_done = 0;
        end else if (m_rem > 0) begin
            if (ack) begin
                m_addr = (m_addr + 2) % 65536;
                m_idx++;
                m_rem--;
                if (m_rem == 0) m_done = 1;
            end
        end else if (dma_req) begin
            m_rem  = (dma_len == '0) ? (1 << LEN_W) : int'(dma_len);
            m_addr = int'(dma_addr & 16'hFFFE);
            m_dir  = dma_we;
            m_idx  = 0;
        end
        @(negedge clk);
        cyc++;
        check("dma_rvalid", dma_rvalid, exp_rvalid);
        check("dma_rdata", dma_rdata, exp_rdata);
        check("dma_done", dma_done, m_done);
        check("led", led, exp_led);
        if (dma_rvalid) n_rv++;
        if (dma_done) begin n_done++; done_cyc = cyc; end
    endtask

    // mode 0: CPU idle; 1: CPU read on odd cycles; 2: random CPU traffic.
    task automatic drive_cpu(input int mode, input int k);
        int r;
        cpu_oe = 1'b0; cpu_we = 1'b0;
        cpu_addr = 16'($urandom); cpu_dout = 16'($urandom);
        if (mode == 1) begin
            cpu_oe = k[0];
            cpu_addr = 16'h4000 + 16'(2 * k);
        end else if (mode == 2) begin
            r = $urandom_range(0, 9);
            if (r <= 2) cpu_oe = 1'b1;
            else if (r <= 4) cpu_we = 1'b1;
            else if (r == 5) begin cpu_oe = 1'b1; cpu_we = 1'b1; end
            if ($urandom_range(0, 3) == 0) cpu_addr = ($urandom_range(0, 1) == 0) ? 16'h0200 : 16'h0202;
        end
    endtask

    task automatic run_burst(input bit we, input logic [15:0] addr, input logic [LEN_W-1:0] len, input int mode);
        int k;
        clear_stats();
        drive_cpu(0, 0);
        dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_len = len;
        req_cyc = cyc;
        tick();
        k = 1;
        while ((m_rem > 0 || m_done) && k < 1500) begin
            drive_cpu(mode, k);
            // Requests during a burst or its completion cycle must be ignored.
            dma_req = 1'($urandom); dma_we = 1'($urandom);
            dma_addr = 16'($urandom); dma_len = LEN_W'($urandom);
            tick();
            k++;
        end
        check("burst_finished_in_budget", (m_rem > 0 || m_done), 0);
        dma_req = 1'b0;
        drive_cpu(0, 0);
        tick();
    endtask

    task automatic compare_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < 32768; i++) if (mem[i] !== ref_mem[i]) bad++;
        check(tag, bad, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        for (int i = 0; i < 32768; i++) begin
            v = 16'($urandom);
            mem[i] = v;
            ref_mem[i] = v;
        end
        model_reset();
        fill_wq();
        rst_n = 1'b0;
        cpu_addr = 16'h1234; cpu_dout = 16'h5678; cpu_oe = 1'b0; cpu_we = 1'b0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_len = '0; dma_wdata = '0;
        @(negedge clk); @(negedge clk);

        // Reset state
        check("rst_busy", dma_busy, 0);
        check("rst_done", dma_done, 0);
        check("rst_rvalid", dma_rvalid, 0);
        check("rst_rdata", dma_rdata, 0);
        check("rst_ack", dma_ack, 0);
        check("rst_led", led, 0);
        check("rst_mem_addr", mem_addr, 16'h1234);
        check("rst_mem_we", mem_we, 0);
        rst_n = 1'b1;
        drive_cpu(0, 0);
        tick();

        // Write burst of 3 at 0x0010 with an idle CPU
        fill_wq();
        wq[0] = 16'h00A1; wq[1] = 16'h00A2; wq[2] = 16'h00A3;
        run_burst(1'b1, 16'h0010, 8'd3, 0);
        check("wr3_acks", n_ack, 3);
        check("wr3_consecutive", last_ack - first_ack, 2);
        check("wr3_done_after_last_ack", done_cyc - last_ack, 1);
        check("wr3_done_pulses", n_done, 1);
        check("wr3_mem0", mem[16'h0010 >> 1], 16'h00A1);
        check("wr3_mem1", mem[16'h0012 >> 1], 16'h00A2);
        check("wr3_mem2", mem[16'h0014 >> 1], 16'h00A3);
        compare_mem("wr3_memory");

        // Single-word burst: done two cycles after the request edge
        fill_wq();
        run_burst(1'b0, 16'h0100, 8'd1, 0);
        check("len1_done_latency", done_cyc - req_cyc, 2);
        check("len1_acks", n_ack, 1);

        // Read burst of 4 from 0x0000 with CPU reads on alternate cycles
        run_burst(1'b0, 16'h0000, 8'd4, 1);
        check("rd4_acks", n_ack, 4);
        check("rd4_rvalid_pulses", n_rv, 4);
        check("rd4_done_pulses", n_done, 1);

        // Address wrap: odd start address, two words
        fill_wq();
        run_burst(1'b1, 16'hFFFF, 8'd2, 0);
        check("wrap_acks", n_ack, 2);
        check("wrap_addr0", ack_addrs.size() > 0 ? ack_addrs[0] : -1, 16'hFFFE);
        check("wrap_addr1", ack_addrs.size() > 1 ? ack_addrs[1] : -1, 16'h0000);
        compare_mem("wrap_memory");

        // Zero length means the full 256 words, under random CPU traffic
        fill_wq();
        run_burst(1'($urandom), 16'($urandom), 8'd0, 2);
        check("len0_acks", n_ack, 256);
        check("len0_done_pulses", n_done, 1);
        compare_mem("len0_memory");

        // LED register writes
        cpu_oe = 1'b0; cpu_we = 1'b1; cpu_addr = 16'h0200; cpu_dout = 16'hBEEF;
        tick();
        cpu_addr = 16'h0202; cpu_dout = 16'h0012;
        tick();
        cpu_we = 1'b0; cpu_oe = 1'b1; cpu_addr = 16'h0200;
        tick();
        drive_cpu(0, 0);
        tick();
        check("mmio_led_value", led, MMIO ? 24'h12BEEF : 24'h000000);
        compare_mem("mmio_memory");

        // Reset during a 5-word write burst after two words
        fill_wq();
        clear_stats();
        drive_cpu(0, 0);
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h3000; dma_len = 8'd5;
        tick();
        dma_req = 1'b0;
        for (int k = 0; k < 20 && n_ack < 2; k++) tick();
        check("abort_acks_before_reset", n_ack, 2);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy_async", dma_busy, 0);
        check("abort_ack", dma_ack, 0);
        check("abort_done", dma_done, 0);
        check("abort_rvalid", dma_rvalid, 0);
        model_reset();
        @(negedge clk);
        check("abort_done_in_reset", dma_done, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check("abort_no_done_after", n_done, 0);
        compare_mem("abort_memory");
        fill_wq();
        run_burst(1'b1, 16'h3100, 8'd3, 0);
        check("after_reset_acks", n_ack, 3);
        check("after_reset_done", n_done, 1);

        // Random bursts under random CPU traffic
        for (int b = 0; b < 20; b++) begin
            int len;
            len = $urandom_range(1, 12);
            fill_wq();
            run_burst(1'($urandom), 16'($urandom), LEN_W'(len), 2);
            check("rand_acks", n_ack, len);
            check("rand_done", n_done, 1);
            if (!m_dir) check("rand_rvalid", n_rv, len);
        end
        compare_mem("rand_memory");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
